hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage core.
// Handles branch flushes, load-use stalls and multi-cycle mul/div stalls.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN;
// without it stall_cycles is tied to zero.
//
// state   | meaning
// RUN     | normal flow; detect branch, mul/div, load-use
// MD_BUSY | mul/div in progress, pipeline frozen, cnt counting down
// MD_DONE | result ready; op still in EX but must not retrigger
module hazard_ctrl #(
  parameter logic [4:0] MUL_OP  = 5'b01110,
  parameter logic [4:0] DIV_OP  = 5'b01111,
  parameter int         MUL_LAT = 4,
  parameter int         DIV_LAT = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic [2:0]  ex_memctrl,
  input  logic [4:0]  ex_aluctrl,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        md_start,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_t      state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic        is_md, is_div, load_use;
  logic        unused_memctrl;

  // Only the load bit of the memory control matters here.
  assign unused_memctrl = ^ex_memctrl[2:1];

  assign is_div   = (ex_aluctrl == DIV_OP);
  assign is_md    = (ex_aluctrl == MUL_OP) || is_div;
  assign load_use = ex_memctrl[0] && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // State and countdown register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and hazard outputs; reset forces every output low.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (is_md) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_flush = 1'b1;
          md_start    = 1'b1;
          cnt_next    = is_div ? DIV_CNT : MUL_CNT;
          state_next  = MD_BUSY;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_flush = 1'b1;
        md_busy     = 1'b1;
        cnt_next    = cnt - 6'd1;
        // <= 1 keeps an out-of-range latency from wrapping the counter
        if (cnt <= 6'd1) state_next = MD_DONE;
      end
      MD_DONE: begin
        state_next = RUN;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
    if (reset) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      md_start    = 1'b0;
      md_busy     = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stats;

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clock) begin
    if (reset)
      stats <= 16'h0000;
    else if (pc_stall && (stats != 16'hFFFF))
      stats <= stats + 16'h0001;
  end

  assign stall_cycles = reset ? 16'h0000 : stats;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  localparam logic [4:0] MUL  = 5'b01110;
  localparam logic [4:0] DIV  = 5'b01111;
  localparam logic [4:0] NOOP = 5'b01101;

  // Output vector order: pc, ifid_stall, idex_stall, ifid_flush,
  // idex_flush, exmem_flush, md_start, md_busy
  localparam logic [7:0] O_IDLE   = 8'b00000000;
  localparam logic [7:0] O_LDUSE  = 8'b11001000;
  localparam logic [7:0] O_BRANCH = 8'b00011000;
  localparam logic [7:0] O_DETECT = 8'b11100110;
  localparam logic [7:0] O_BUSY   = 8'b11100101;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt, ex_aluctrl;
  logic [2:0]  ex_memctrl;
  logic        branch_taken;
  logic        pc_stall, ifid_stall, idex_stall;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        md_start, md_busy;
  logic [15:0] stall_cycles;
  logic [7:0]  outs;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rt        (ex_rt),
    .ex_memctrl   (ex_memctrl),
    .ex_aluctrl   (ex_aluctrl),
    .branch_taken (branch_taken),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  assign outs = {pc_stall, ifid_stall, idex_stall, ifid_flush,
                 idex_flush, exmem_flush, md_start, md_busy};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    ex_rt        = 5'd0;
    ex_memctrl   = 3'b000;
    ex_aluctrl   = NOOP;
    branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_aluctrl = MUL; branch_taken = 1'b1; ex_memctrl = 3'b001;
    ex_rt = 5'd3; id_rs = 5'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (outs !== O_IDLE) begin
        bad++;
        $display("FAIL reset_outs[%0d]: got %b want %b", i, outs, O_IDLE);
      end
      total++;
      if (stall_cycles !== 16'h0000) begin
        bad++;
        $display("FAIL reset_stats[%0d]: got %h want 0000", i, stall_cycles);
      end
      next_cycle();
    end
    reset = 1'b0;
    set_idle();
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    ex_memctrl = 3'b001; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    #1;
    total++;
    if (outs !== O_LDUSE) begin
      bad++;
      $display("FAIL load_use_rs: got %b want %b", outs, O_LDUSE);
    end
    next_cycle();
    set_idle();
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL load_use_after: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
    ex_memctrl = 3'b001; ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
    #1;
    total++;
    if (outs !== O_LDUSE) begin
      bad++;
      $display("FAIL load_use_rt: got %b want %b", outs, O_LDUSE);
    end
    next_cycle();
    ex_memctrl = 3'b001; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL load_use_r0: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
    ex_memctrl = 3'b010; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL store_no_stall: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
    ex_memctrl = 3'b001; ex_rt = 5'd5; id_rs = 5'd6; id_rt = 5'd4;
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL load_no_match: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
    set_idle();
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    #1;
    total++;
    if (outs !== O_BRANCH) begin
      bad++;
      $display("FAIL branch: got %b want %b", outs, O_BRANCH);
    end
    next_cycle();
    branch_taken = 1'b1; ex_memctrl = 3'b001; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    total++;
    if (outs !== O_BRANCH) begin
      bad++;
      $display("FAIL priority_branch_loaduse: got %b want %b", outs, O_BRANCH);
    end
    next_cycle();
    set_idle();
    branch_taken = 1'b1; ex_aluctrl = MUL;
    #1;
    total++;
    if (outs !== O_BRANCH) begin
      bad++;
      $display("FAIL priority_branch_mul: got %b want %b", outs, O_BRANCH);
    end
    next_cycle();
    set_idle();
  endtask

  // Op held for LAT stall cycles plus the MD_DONE cycle.
  task automatic run_md(input logic [4:0] op, input int lat, input string tag);
    int n_stall = 0, n_busy = 0, n_start = 0;
    logic [7:0] want;
    ex_aluctrl = op;
    for (int i = 0; i <= lat; i++) begin
      if (i == lat / 2) branch_taken = 1'b1;
      if (i == lat / 2 + 1) branch_taken = 1'b0;
      #1;
      want = (i == 0) ? O_DETECT : (i < lat) ? O_BUSY : O_IDLE;
      total++;
      if (outs !== want) begin
        bad++;
        $display("FAIL %s_cycle%0d: got %b want %b", tag, i, outs, want);
      end
      n_stall += int'(pc_stall);
      n_busy  += int'(md_busy);
      n_start += int'(md_start);
      next_cycle();
    end
    branch_taken = 1'b0;
    total++;
    if (n_stall !== lat) begin
      bad++;
      $display("FAIL %s_stall_count: got %0d want %0d", tag, n_stall, lat);
    end
    total++;
    if (n_busy !== lat - 1) begin
      bad++;
      $display("FAIL %s_busy_count: got %0d want %0d", tag, n_busy, lat - 1);
    end
    total++;
    if (n_start !== 1) begin
      bad++;
      $display("FAIL %s_start_count: got %0d want 1", tag, n_start);
    end
  endtask

  task automatic test_mul();
    run_md(MUL, 4, "mul");
    set_idle();
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL mul_after: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_div();
    run_md(DIV, 32, "div");
    set_idle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    run_md(MUL, 4, "b2b_first");
    run_md(MUL, 4, "b2b_second");
    set_idle();
    next_cycle();
  endtask

  task automatic test_done_load_use();
    ex_aluctrl = MUL;
    for (int i = 0; i < 4; i++) next_cycle();
    ex_memctrl = 3'b001; ex_rt = 5'd12; id_rt = 5'd12;
    #1;
    total++;
    if (outs !== O_LDUSE) begin
      bad++;
      $display("FAIL done_load_use: got %b want %b", outs, O_LDUSE);
    end
    next_cycle();
    set_idle();
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    ex_aluctrl = MUL;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL mid_reset_during: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
    reset = 1'b0;
    set_idle();
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL mid_reset_after: got %b want %b", outs, O_IDLE);
    end
    total++;
    if (stall_cycles !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset_stats: got %h want 0000", stall_cycles);
    end
    next_cycle();
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL mid_reset_settled: got %b want %b", outs, O_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_stats();
    logic [15:0] want;
`ifdef HAZARD_STATS_EN
    want = 16'd5;
`else
    want = 16'd0;
`endif
    reset = 1'b1;
    set_idle();
    next_cycle();
    reset = 1'b0;
    ex_aluctrl = MUL;
    for (int i = 0; i < 5; i++) next_cycle();
    set_idle();
    ex_memctrl = 3'b001; ex_rt = 5'd3; id_rs = 5'd3;
    next_cycle();
    set_idle();
    #1;
    total++;
    if (stall_cycles !== want) begin
      bad++;
      $display("FAIL stats_count: got %0d want %0d", stall_cycles, want);
    end
    next_cycle();
    total++;
    if (stall_cycles !== want) begin
      bad++;
      $display("FAIL stats_hold: got %0d want %0d", stall_cycles, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    next_cycle();
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_div();
    test_back_to_back();
    test_done_load_use();
    test_reset_mid_op();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
